// File: rtl/pc_sequencer.sv
// Fetch-PC generator: owns the IF-stage PC, resolves ID branches/jumps, applies
// exception/eret redirects and buffers one redirect while imem is not ready.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_4180),
  parameter bit               DELAY_SLOT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             if_ready,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [2:0]       id_kind,
  input  logic [2:0]       id_cond,
  input  logic [15:0]      id_imm16,
  input  logic [25:0]      id_index26,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic             if_req,
  output logic             flush_if,
  output logic             if_bd,
  output logic             pc_misalign,
  output logic             jump,
  output logic             back
);

  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_J      = 3'd2;
  localparam logic [2:0] KIND_JAL    = 3'd3;
  localparam logic [2:0] KIND_JR     = 3'd4;
  localparam logic [2:0] KIND_JALR   = 3'd5;

  localparam logic [2:0] COND_BEQ  = 3'd0;
  localparam logic [2:0] COND_BNE  = 3'd1;
  localparam logic [2:0] COND_BLEZ = 3'd2;
  localparam logic [2:0] COND_BGTZ = 3'd3;
  localparam logic [2:0] COND_BLTZ = 3'd4;
  localparam logic [2:0] COND_BGEZ = 3'd5;

  // Bits of the sequential PC that a J/JAL index replaces.
  localparam logic [WIDTH-1:0] JIDX_LO_MASK = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic             adv;
  logic             is_branch, is_jidx, is_jreg, is_ctrl;
  logic             br_taken;
  logic             redir;
  logic [WIDTH-1:0] id_pc4;
  logic [31:0]      br_off32;
  logic [WIDTH-1:0] br_target, jidx_target, jreg_target, target;
  logic signed [31:0] rs_s;

  assign adv = if_ready & ~stall;

  always_comb begin
    is_branch = 1'b0;
    is_jidx   = 1'b0;
    is_jreg   = 1'b0;
    case (id_kind)
      KIND_BRANCH:        is_branch = 1'b1;
      KIND_J, KIND_JAL:   is_jidx   = 1'b1;
      KIND_JR, KIND_JALR: is_jreg   = 1'b1;
      default:            ;
    endcase
    is_ctrl = is_branch | is_jidx | is_jreg;
  end

  assign rs_s = $signed(rs_val);

  always_comb begin
    br_taken = 1'b0;
    case (id_cond)
      COND_BEQ:  br_taken = (rs_val == rt_val);
      COND_BNE:  br_taken = (rs_val != rt_val);
      COND_BLEZ: br_taken = (rs_s <= 32'sd0);
      COND_BGTZ: br_taken = (rs_s >  32'sd0);
      COND_BLTZ: br_taken = (rs_s <  32'sd0);
      COND_BGEZ: br_taken = (rs_s >= 32'sd0);
      default:   br_taken = 1'b0;
    endcase
  end

  assign redir = id_valid & ((is_branch & br_taken) | is_jidx | is_jreg);

  assign id_pc4      = id_pc + WIDTH'(4);
  assign br_off32    = {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign br_target   = id_pc4 + br_off32[WIDTH-1:0];
  assign jidx_target = (id_pc4 & ~JIDX_LO_MASK) | WIDTH'({id_index26, 2'b00});
  assign jreg_target = rs_val[WIDTH-1:0];

  always_comb begin
    target = br_target;
    if (is_jidx) begin
      target = jidx_target;
    end else if (is_jreg) begin
      target = jreg_target;
    end
  end

  // Exception beats eret; both discard any buffered redirect regardless of adv.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (exc_req) begin
      pc_d         = EXC_VEC;
      pend_valid_d = 1'b0;
    end else if (eret_req) begin
      pc_d         = epc;
      pend_valid_d = 1'b0;
    end else if (adv && pend_valid_q) begin
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
    end else if (adv && redir) begin
      pc_d = target;
    end else if (adv) begin
      pc_d = pc_q + WIDTH'(4);
    end else if (redir && !pend_valid_q) begin
      pend_valid_d  = 1'b1;
      pend_target_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  logic redirect_flush;
  logic bd_flag;

  generate
    if (DELAY_SLOT) begin : g_delay_slot
      assign redirect_flush = 1'b0;
      assign bd_flag        = id_valid & is_ctrl;
    end else begin : g_no_delay_slot
      // The fetched instruction is wrong-path whenever a redirect lands.
      assign redirect_flush = adv & (pend_valid_q | redir);
      assign bd_flag        = 1'b0;
    end
  endgenerate

  assign flush_if    = ~reset & (exc_req | eret_req | redirect_flush);
  assign if_bd       = bd_flag;
  assign jump        = id_valid & is_ctrl;
  assign pc          = pc_q;
  assign pc_misalign = |pc_q[1:0];
  assign if_req      = ~reset;
  assign back        = eret_req;

endmodule
